// File: rtl/uart_pkg.sv
// Shared constants and types for the D-bus UART blocks.
// Register map, status/control bit positions and bus encodings.
package uart_pkg;

  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam int CTRL_IE    = 0;
  localparam int CTRL_FLUSH = 1;

  localparam logic TT_READ  = 1'b0;
  localparam logic TT_WRITE = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and clear.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign rdata   = mem[rp_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 transmit-only UART on the D-bus.
// Bytes queue in a FIFO and are shifted out LSB first on tx.
module dbus_uart_tx
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic        bstart,
  input  logic        ttype,
  input  logic [1:0]  tsize,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e state_q, state_d;

  logic [15:0] div_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        ie_q, ovf_q;
  logic        tx_q, irq_q, bdone_q;
  logic [31:0] rdata_q, rd_val;

  logic          acc, wr_en;
  logic          sel_data, sel_status;
  logic          sel_div, sel_ctrl;
  logic          push, pop, flush;
  logic          full, empty, busy;
  logic          bit_end;
  logic [CW-1:0] count;
  logic [7:0]    count8, head;
  logic          unused;

  assign acc        = ss && bstart;
  assign wr_en      = acc && (ttype == TT_WRITE);
  assign sel_data   = (addr[3:2] == UART_DATA[3:2]);
  assign sel_status = (addr[3:2] == UART_STATUS[3:2]);
  assign sel_div    = (addr[3:2] == UART_DIV[3:2]);
  assign sel_ctrl   = (addr[3:2] == UART_CTRL[3:2]);
  assign push       = wr_en && sel_data;
  assign flush      = wr_en && sel_ctrl && wdata[CTRL_FLUSH];
  assign busy       = (state_q != IDLE);
  assign bit_end    = (cnt_q == '0);
  assign count8     = 8'(count);
  assign unused     = ^{addr[1:0], wdata[31:16]};

  assign rdata = rdata_q;
  assign bdone = bdone_q;
  assign tx    = tx_q;
  assign irq   = irq_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata[7:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_status: rd_val = {16'h0, count8, 4'h0,
                            ovf_q, busy, empty, full};
      sel_div:    rd_val = {16'h0, div_q};
      sel_ctrl:   rd_val[CTRL_IE] = ie_q;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdone_q <= 1'b0;
      rdata_q <= '0;
      div_q   <= DIV_RESET;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bdone_q <= acc;
      rdata_q <= (acc && ttype == TT_READ) ? rd_val : '0;
      if (wr_en && sel_div) begin
        div_q[7:0] <= wdata[7:0];
        if (tsize != SZ_BYTE) div_q[15:8] <= wdata[15:8];
      end
      if (wr_en && sel_ctrl) ie_q <= wdata[CTRL_IE];
      if (push && full && !pop)
        ovf_q <= 1'b1;
      else if (wr_en && sel_status && wdata[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

  // STOP chains straight into START when more bytes wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = div_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            cnt_d   = div_q;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? sh_q[0] : 1'b1;
      irq_q   <= ie_q && empty && !busy;
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx with a serial-line receiver
// checking every frame against a queue of expected bytes.
module tb_dbus_uart_tx;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ss;
  logic        bstart;
  logic        ttype;
  logic [1:0]  tsize;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;
  logic        tx;
  logic        irq;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] rd;
  logic [15:0] div_m = 16'd867;
  logic [7:0]  exp_q[$];

  dbus_uart_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ss     (ss),
    .bstart (bstart),
    .ttype  (ttype),
    .tsize  (tsize),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .bdone  (bdone),
    .tx     (tx),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h",
             tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b,
                                input int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[k];
  endfunction

  task automatic acc(input logic w, input logic [3:0] a,
                     input logic [31:0] d,
                     input logic [1:0] sz);
    ss     = 1'b1;
    bstart = 1'b1;
    ttype  = w;
    addr   = a;
    wdata  = d;
    tsize  = sz;
    @(posedge clk);
    #1;
    chk("bdone", {31'b0, bdone}, 32'h1);
    rd = rdata;
  endtask

  task automatic bus_idle();
    ss     = 1'b0;
    bstart = 1'b0;
  endtask

  task automatic wait_idle(input int max_polls);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_polls && !done; k++) begin
      acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
      bus_idle();
      if (rd[2:1] == 2'b01) done = 1'b1;
      else repeat (15) @(posedge clk);
    end
    chk("idle_timeout", {31'b0, done}, 32'h1);
  endtask

  // Serial receiver: samples mid-bit, aborts on reset.
  initial begin
    int p;
    int n;
    int j;
    logic [9:0] obs;
    logic [7:0] e;
    forever begin
      @(negedge tx);
      if (rst_n === 1'b1) begin
        p = int'(div_m) + 1;
        n = 0;
        j = 0;
        obs = '0;
        while (j < 10) begin
          @(negedge clk);
          n++;
          if (rst_n !== 1'b1) break;
          if (n == j * p + p / 2 + 1) begin
            obs[j] = tx;
            j++;
          end
        end
        if (j == 10) begin
          chk("rx_expected", {31'b0, exp_q.size() > 0}, 32'h1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_frame", {22'b0, obs}, {22'b0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst_n  = 1'b0;
    ss     = 1'b0;
    bstart = 1'b0;
    ttype  = TT_READ;
    tsize  = SZ_WORD;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_bdone", {31'b0, bdone}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_rst", rd, 32'h0000_0002);
    acc(TT_READ, UART_DIV, 32'h0, SZ_WORD);
    chk("div_rst", rd, 32'h0000_0363);
    acc(TT_READ, UART_DATA, 32'h0, SZ_WORD);
    chk("data_read", rd, 32'h0);
    bus_idle();
    @(posedge clk);
    #1;
    chk("bdone_pulse", {31'b0, bdone}, 32'h0);
    chk("tx_idle", {31'b0, tx}, 32'h1);

    // Single frame, 4-cycle bits
    acc(TT_WRITE, UART_DIV, 32'h3, SZ_WORD);
    div_m = 16'd3;
    exp_q.push_back(8'h55);
    acc(TT_WRITE, UART_DATA, 32'h0000_0055, SZ_WORD);
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    chk("tx_latency", {31'b0, tx}, 32'h1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("tx55_%0d", c), {31'b0, tx},
          {31'b0, fbit(8'h55, c / 4)});
    end
    @(negedge clk);
    chk("tx55_after", {31'b0, tx}, 32'h1);
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_done55", rd, 32'h0000_0002);
    bus_idle();

    // Back-to-back frames with DIV=0
    acc(TT_WRITE, UART_DIV, 32'h0, SZ_WORD);
    div_m = 16'd0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    acc(TT_WRITE, UART_DATA, 32'h0000_00A5, SZ_BYTE);
    acc(TT_WRITE, UART_DATA, 32'hFFFF_FF3C, SZ_WORD);
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_cnt1", rd, 32'h0000_0104);
    bus_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("tx2f_%0d", c), {31'b0, tx},
          {31'b0, fbit(c < 10 ? 8'hA5 : 8'h3C, c % 10)});
    end
    @(negedge clk);
    chk("tx2f_after", {31'b0, tx}, 32'h1);
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_done2f", rd, 32'h0000_0002);
    bus_idle();

    // Fill and overflow the FIFO
    acc(TT_WRITE, UART_DIV, 32'd100, SZ_WORD);
    div_m = 16'd100;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'h10 + 8'(i));
      acc(TT_WRITE, UART_DATA, 32'h10 + 32'(i), SZ_WORD);
    end
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_ovf", rd, 32'h0000_080D);
    acc(TT_WRITE, UART_STATUS, 32'h8, SZ_WORD);
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_w1c", rd, 32'h0000_0805);
    bus_idle();
    wait_idle(1000);
    chk("q_drain_ovf", exp_q.size(), 32'h0);

    // Interrupt around one frame
    acc(TT_WRITE, UART_DIV, 32'h1, SZ_WORD);
    div_m = 16'd1;
    acc(TT_WRITE, UART_CTRL, 32'h1, SZ_WORD);
    bus_idle();
    @(posedge clk);
    #1;
    chk("irq_idle", {31'b0, irq}, 32'h1);
    acc(TT_READ, UART_CTRL, 32'h0, SZ_WORD);
    chk("ctrl_ie", rd, 32'h1);
    exp_q.push_back(8'h96);
    acc(TT_WRITE, UART_DATA, 32'h96, SZ_WORD);
    bus_idle();
    @(negedge clk);
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (irq !== 1'b0) hi++;
    end
    chk("irq_frame", hi, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("irq_after", {31'b0, irq}, 32'h1);

    // Flush with four queued bytes
    exp_q.push_back(8'hA1);
    for (int i = 0; i < 5; i++)
      acc(TT_WRITE, UART_DATA, 32'hA1 + 32'(i), SZ_WORD);
    acc(TT_WRITE, UART_CTRL, 32'h3, SZ_WORD);
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_flush", rd, 32'h0000_0006);
    acc(TT_READ, UART_CTRL, 32'h0, SZ_WORD);
    chk("ctrl_flush_rd", rd, 32'h1);
    bus_idle();
    wait_idle(100);
    repeat (5) @(posedge clk);
    #1;
    chk("q_drain_flush", exp_q.size(), 32'h0);
    chk("irq_flush", {31'b0, irq}, 32'h1);

    // Partial-size DIV writes
    acc(TT_WRITE, UART_DIV, 32'h1234_56FF, SZ_BYTE);
    acc(TT_READ, UART_DIV, 32'h0, SZ_WORD);
    chk("div_byte", rd, 32'h0000_00FF);
    acc(TT_WRITE, UART_DIV, 32'hABCD_1234, SZ_HALF);
    acc(TT_READ, UART_DIV, 32'h0, SZ_WORD);
    chk("div_half", rd, 32'h0000_1234);
    bus_idle();
    div_m = 16'h1234;

    // Reset in the middle of the data bits
    acc(TT_WRITE, UART_DIV, 32'h3, SZ_WORD);
    div_m = 16'd3;
    acc(TT_WRITE, UART_DATA, 32'h0, SZ_WORD);
    bus_idle();
    repeat (11) @(posedge clk);
    #2;
    chk("tx_mid_data", {31'b0, tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("tx_async_rst", {31'b0, tx}, 32'h1);
    exp_q.delete();
    div_m = 16'd867;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc(TT_READ, UART_STATUS, 32'h0, SZ_WORD);
    chk("status_rst2", rd, 32'h0000_0002);
    acc(TT_READ, UART_DIV, 32'h0, SZ_WORD);
    chk("div_rst2", rd, 32'h0000_0363);
    acc(TT_READ, UART_CTRL, 32'h0, SZ_WORD);
    chk("ctrl_rst2", rd, 32'h0);
    bus_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("tx_end", {31'b0, tx}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_uart_tx.md
Name: dbus_uart_tx

Overview:
- Memory-mapped transmit-only UART. A D-bus slave that sits downstream of the D-bus interconnect, next to the GPIO and data memory.
- The core writes bytes into an internal TX FIFO. A baud-rate FSM serialises them 8N1, LSB first, onto a single tx line.
- Status and divisor registers are software-visible. An interrupt output flags when the FIFO has drained.

Parameters:
- FIFO_DEPTH, 8, number of TX FIFO entries; power of two, 2..64.
- DIV_RESET, 16'd867, reset value of the baud divisor. Bit period = DIV+1 clk cycles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ss  input  1  slave select from D-bus interconnect (address decoded to this block).
- bstart  input  1  bus transaction start strobe.
- ttype  input  1  0=READ, 1=WRITE.
- tsize  input  2  0=BYTE, 1=HALFWORD, 2=WORD.
- addr  input  4  byte offset within the block.
- wdata  input  32  write data.
- rdata  output  32  read data, valid while bdone=1.
- bdone  output  1  transaction complete, one-cycle pulse.
- tx  output  1  serial line, idle high.
- irq  output  1  level interrupt: FIFO empty and shifter idle, gated by CTRL.ie.

Behaviour:
- Register map (word aligned; addr[1:0] ignored):
  - 0x0 DATA: write pushes wdata[7:0]; read returns 0.
  - 0x4 STATUS, read-only except bit 3:
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky; W1C).
    - bits[15:8] FIFO count.
  - 0x8 DIV: bits[15:0], R/W.
  - 0xC CTRL: bit0 ie (interrupt enable), bit1 flush (write 1 = empty the FIFO; self-clearing, reads 0).
- Unmapped offsets: reads return 0; writes have no effect. All accesses still complete with bdone.
- Bus handshake: an access is accepted when ss && bstart at a posedge. bdone=1 exactly one cycle later, with rdata registered. No wait states.
  - ss && bstart asserted while bdone=1 is accepted normally, giving back-to-back accesses each cycle.
- tsize: any size writes the low bytes per wdata. Writes to DATA of any size push exactly one byte. Reads always return the full 32-bit register.
- DATA write while full: byte dropped, overflow set, FIFO unchanged.
- Simultaneous push and pop in one cycle: both take effect and count is unchanged. A push to a full FIFO while popping in the same cycle is accepted.
- Reset values: tx=1, bdone=0, rdata=0, irq=0, FIFO empty, overflow=0, DIV=DIV_RESET, ie=0, FSM IDLE.
- Baud counter: loads DIV at each bit start, decrements to 0, then the bit ends. DIV=0 gives a 1-cycle bit period.
- TX FSM:
  - IDLE: tx=1. If FIFO not empty, pop the head into an 8-bit shifter → START.
  - START: tx=0 for one bit period → DATA.
  - DATA: tx=shifter[0]; shift right at each bit end. After 8 bits → STOP.
  - STOP: tx=1 for one bit period. Then → START if FIFO not empty (popping the next byte, with no idle bit), else → IDLE.
- busy = (state != IDLE).
- DIV write during a frame takes effect at the next bit start. Flush during a frame does not abort the byte in the shifter.
- Frame latency: tx falls 2 cycles after the DATA-write acceptance edge (push edge + pop edge). Frame length = 10*(DIV+1) cycles.
- irq = ie && empty && !busy, registered.
- rst_n assertion mid-frame: immediately tx=1, FSM IDLE, FIFO cleared.

Decomposition:
- Package uart_pkg:
  - register offset localparams (UART_DATA, UART_STATUS, UART_DIV, UART_CTRL);
  - STATUS/CTRL bit-index constants;
  - typedef enum logic[1:0] {IDLE, START, DATA, STOP} uart_tx_state_e;
  - ttype/tsize encodings shared with the bus interfaces.
- Sub-module: sync_fifo. Parameterised WIDTH/DEPTH; push, pop, full, empty, count. Reusable for a later RX block.

Test Plan:
- Reset, then read 0x4 → rdata=0x0000_0002 (empty); read 0x8 → 0x0000_0363; tx=1 throughout.
- Write DIV=3, write DATA=0x55 → tx low 2 cycles after acceptance. Bits are 4 cycles each: 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop). Frame is 40 cycles; busy=0 after.
- DIV=0, write 0xA5 then 0x3C back-to-back → two frames with no idle gap, 20 cycles total. STATUS count reads 1 after the first pop.
- FIFO_DEPTH=8, DIV=100: write 10 bytes in consecutive cycles. First byte is popped to the shifter, so 9 remain queued and the FIFO fills. One byte is dropped: overflow=1, full=1, count=8. Write 0x8 to 0x4 → overflow=0.
- Enable ie, send one byte with DIV=1 → irq=0 during the frame, irq=1 within 2 cycles after STOP ends. Set CTRL.flush with 4 queued bytes → only the in-flight byte is transmitted.
- Assert rst_n=0 mid-DATA → tx=1 asynchronously. After release, STATUS=0x2 and DIV=0x363.
